// File: rtl/bs_config_chain_pkg.sv
// ---------------------------------------------------------------------------
// bs_config_chain_pkg
// Shared definitions for the serial configuration chain:
//   state_t          - frame FSM states (IDLE, LOAD, CHECK)
//   CRC_W            - CRC register width (8)
//   DEFAULT_CRC_POLY - default CRC-8 generator polynomial (x^8 implicit)
//   crc8Step         - one-bit CRC-8 update, MSB-first
// ---------------------------------------------------------------------------
package bs_config_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] DEFAULT_CRC_POLY = 8'h07;

  // Feedback is the outgoing MSB xor the incoming bit; the polynomial is
  // folded in only when that feedback is set.
  function automatic logic [CRC_W-1:0] crc8Step(input logic [CRC_W-1:0] crc,
                                                input logic             din,
                                                input logic [CRC_W-1:0] poly);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/bs_config_chain_crc8.sv
// ---------------------------------------------------------------------------
// bs_crc8_serial
// Bit-serial CRC-8 register.
//   clk, reset - clock, asynchronous active-high reset
//   clear_i    - restart from 8'h00 (combined with en_i, the first bit is
//                folded into a zero seed in the same cycle)
//   en_i       - fold bit_i into the CRC this cycle
//   bit_i      - serial data bit
//   zero_o     - CRC register currently equals zero
// ---------------------------------------------------------------------------
module bs_crc8_serial
  import bs_config_chain_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEFAULT_CRC_POLY
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  input  logic bit_i,
  output logic zero_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CRC_W-1:0] seed;

  // Next-state: a clear seeds the update with zero so a frame's first bit
  // can be absorbed on the same edge that leaves IDLE.
  always_comb begin
    seed  = clear_i ? {CRC_W{1'b0}} : crc_q;
    crc_d = crc_q;
    if (en_i) begin
      crc_d = crc8Step(seed, bit_i, POLY);
    end else if (clear_i) begin
      crc_d = {CRC_W{1'b0}};
    end
  end

  // CRC state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= {CRC_W{1'b0}};
    end else begin
      crc_q <= crc_d;
    end
  end

  assign zero_o = (crc_q == {CRC_W{1'b0}});

endmodule

// File: rtl/bs_config_chain.sv
// ---------------------------------------------------------------------------
// bs_config_chain
// Serial, CRC-protected configuration loader with double buffering.
// A frame is BS_LENGTH payload bits then 8 CRC bits, MSB first, one bit per
// cycle while config_en is high. The payload shifts into a staging register;
// it is copied to cfg_q only when the frame length and CRC both check out.
//   clk, reset  - clock, asynchronous active-high reset
//   config_en   - bs_in carries a frame bit this cycle
//   bs_in       - serial frame data
//   bs_out      - daisy-chain output (staging register MSB)
//   cfg_q       - committed configuration
//   cfg_valid   - a frame has committed since reset
//   cfg_err     - last completed frame was rejected
//   busy        - FSM is in LOAD or CHECK
//   commit_cnt  - committed frame count, wraps at 256
// ---------------------------------------------------------------------------
module bs_config_chain
  import bs_config_chain_pkg::*;
#(
  parameter int               BS_LENGTH = 576,
  parameter logic [CRC_W-1:0] CRC_POLY  = DEFAULT_CRC_POLY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 config_en,
  input  logic                 bs_in,
  output logic                 bs_out,
  output logic [BS_LENGTH-1:0] cfg_q,
  output logic                 cfg_valid,
  output logic                 cfg_err,
  output logic                 busy,
  output logic [7:0]           commit_cnt
);

  localparam int CW = $clog2(BS_LENGTH + 10);
  localparam logic [CW-1:0] LEN_C  = CW'(BS_LENGTH);
  localparam logic [CW-1:0] GOOD_C = CW'(BS_LENGTH + 8);
  localparam logic [CW-1:0] SAT_C  = CW'(BS_LENGTH + 9);

  state_t                 state_q;
  logic [CW-1:0]          count_q;
  logic [BS_LENGTH-1:0]   shiftReg_q;
  logic                   crcZero;
  logic                   crcClear;
  logic                   crcEn;

  // The CRC restarts whenever we sit in IDLE; bits arriving during CHECK
  // are dropped, so they must not reach the CRC either.
  assign crcClear = (state_q == IDLE);
  assign crcEn    = config_en && (state_q != CHECK);

  bs_crc8_serial #(
    .POLY(CRC_POLY)
  ) u_crc (
    .clk     (clk),
    .reset   (reset),
    .clear_i (crcClear),
    .en_i    (crcEn),
    .bit_i   (bs_in),
    .zero_o  (crcZero)
  );

  // Frame FSM with its datapath. The counter holds the number of frame bits
  // seen so far; it saturates one past the legal length so an overlong frame
  // can never wrap back onto the good count. Only payload positions shift the
  // staging register; trailer bits feed the CRC alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shiftReg_q <= '0;
      cfg_q      <= '0;
      cfg_valid  <= 1'b0;
      cfg_err    <= 1'b0;
      commit_cnt <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (config_en) begin
            state_q    <= LOAD;
            count_q    <= CW'(1);
            shiftReg_q <= {shiftReg_q[BS_LENGTH-2:0], bs_in};
          end
        end
        LOAD: begin
          if (config_en) begin
            if (count_q < LEN_C) begin
              shiftReg_q <= {shiftReg_q[BS_LENGTH-2:0], bs_in};
            end
            if (count_q != SAT_C) begin
              count_q <= count_q + CW'(1);
            end
          end else begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if ((count_q == GOOD_C) && crcZero) begin
            cfg_q      <= shiftReg_q;
            cfg_valid  <= 1'b1;
            cfg_err    <= 1'b0;
            commit_cnt <= commit_cnt + 8'd1;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bs_out = shiftReg_q[BS_LENGTH-1];
  assign busy   = (state_q != IDLE);

endmodule
